signed_alu_seq: RTL and testbench

Arithmetic stage that directly consumes the two's-complement operands and opcode produced by the complement stage. On a rising edge of `alu_sel`, it captures the two 4-bit signed operands and the 4-bit operation code. It then computes an 8-bit signed result: add and subtract take a single cycle, and multiply uses a 4-iteration shift-add sequence. It holds the result with a level `alu_finish` flag for the following display/output stage.

---
 rtl/signed_alu_seq_pkg.sv | 31 +++
 rtl/signed_alu_seq_if.sv | 26 ++
 rtl/signed_alu_seq_shift_add_mul4.sv | 56 +++++
 rtl/signed_alu_seq.sv | 104 ++++++++++
 tb/tb_signed_alu_seq.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/signed_alu_seq_pkg.sv
// alu_pkg: shared constants and helpers for the signed ALU stage.
//   - W_IN / W_OUT : operand and result widths
//   - OP_*         : opcode encodings (anything else is invalid)
//   - ST_*         : FSM state encoding
//   - sext8, mag4  : sign extension and magnitude helpers
package alu_pkg;

  localparam int W_IN  = 4;
  localparam int W_OUT = 8;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Sign-extend a 4-bit two's-complement operand to the result width.
  function automatic logic [W_OUT-1:0] sext8(input logic [W_IN-1:0] v);
    return {{(W_OUT-W_IN){v[W_IN-1]}}, v};
  endfunction

  // Unsigned magnitude of a 4-bit signed value. -8 wraps to 4'b1000,
  // which read as unsigned is exactly 8, so no extra bit is needed.
  function automatic logic [W_IN-1:0] mag4(input logic [W_IN-1:0] v);
    return v[W_IN-1] ? (~v + 4'd1) : v;
  endfunction

endpackage

// File: rtl/signed_alu_seq_if.sv
// signed_alu_seq_if: request/result bundle between the complement stage,
// the ALU and the display stage.
//   master : drives alu_sel, first_nr, second_nr, operation
//   slave  : drives result, alu_finish, alu_busy, op_error
interface signed_alu_seq_if;
  import alu_pkg::*;

  logic             alu_sel;
  logic [W_IN-1:0]  first_nr;
  logic [W_IN-1:0]  second_nr;
  logic [3:0]       operation;
  logic [W_OUT-1:0] result;
  logic             alu_finish;
  logic             alu_busy;
  logic             op_error;

  modport master (
    output alu_sel, first_nr, second_nr, operation,
    input  result, alu_finish, alu_busy, op_error
  );

  modport slave (
    input  alu_sel, first_nr, second_nr, operation,
    output result, alu_finish, alu_busy, op_error
  );
endinterface

// File: rtl/signed_alu_seq_shift_add_mul4.sv
// shift_add_mul4: unsigned 4x4 sequential shift-add multiplier.
//   clk, rst (sync, active-low)
//   load  : capture a_mag/b_mag and start 4 iterations on following edges
//   a_mag, b_mag : unsigned operands 0..8
//   prod  : product including the iteration that the next edge performs,
//           so it is final while done is high
//   done  : high during the cycle whose edge performs the last iteration
module shift_add_mul4
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [W_IN-1:0] a_mag,
  input  logic [W_IN-1:0] b_mag,
  output logic [6:0]      prod,
  output logic            done
);

  logic [6:0]      a_sh_reg;
  logic [W_IN-1:0] b_reg;
  logic [6:0]      acc_reg;
  logic [1:0]      it_reg;
  logic            run_reg;
  logic [6:0]      acc_next;

  // Max product is 8*8 = 64, which fits 7 bits without carry-out.
  assign acc_next = acc_reg + (b_reg[0] ? a_sh_reg : 7'd0);
  assign prod     = acc_next;
  assign done     = run_reg && (it_reg == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_sh_reg <= '0;
      b_reg    <= '0;
      acc_reg  <= '0;
      it_reg   <= '0;
      run_reg  <= 1'b0;
    end else if (load) begin
      a_sh_reg <= {3'b000, a_mag};
      b_reg    <= b_mag;
      acc_reg  <= '0;
      it_reg   <= '0;
      run_reg  <= 1'b1;
    end else if (run_reg) begin
      acc_reg  <= acc_next;
      a_sh_reg <= a_sh_reg << 1;
      b_reg    <= b_reg >> 1;
      it_reg   <= it_reg + 2'd1;
      if (it_reg == 2'd3) begin
        run_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/signed_alu_seq.sv
// signed_alu_seq: signed 4-bit ALU stage (ADD/SUB in one cycle, MUL via a
// 4-iteration shift-add core). Starts on a rising edge of alu_sel and holds
// the 8-bit sign-extended result with a level alu_finish flag.
//   clk : clock, all logic on posedge
//   rst : synchronous active-low reset
//   bus : signed_alu_seq_if.slave (alu_sel, operands, opcode in;
//         result, alu_finish, alu_busy, op_error out)
module signed_alu_seq
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  signed_alu_seq_if.slave bus
);

  logic [1:0]       state_reg;
  logic             sel_q;
  logic [W_IN-1:0]  a_reg;
  logic [W_IN-1:0]  b_reg;
  logic [3:0]       op_reg;
  logic             neg_reg;
  logic [W_OUT-1:0] result_reg;
  logic             finish_reg;
  logic             err_reg;

  logic             start;
  logic             accept;
  logic             mul_load;
  logic [6:0]       mul_prod;
  logic             mul_done;
  logic [W_OUT-1:0] mul_mag;

  assign start    = bus.alu_sel & ~sel_q;
  // Starts are only honoured when no operation is running; they are not queued.
  assign accept   = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign mul_load = accept && (bus.operation == OP_MUL);
  assign mul_mag  = {1'b0, mul_prod};

  shift_add_mul4 u_mul (
    .clk   (clk),
    .rst   (rst),
    .load  (mul_load),
    .a_mag (mag4(bus.first_nr)),
    .b_mag (mag4(bus.second_nr)),
    .prod  (mul_prod),
    .done  (mul_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      sel_q      <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      neg_reg    <= 1'b0;
      result_reg <= '0;
      finish_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      sel_q <= bus.alu_sel;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            a_reg      <= bus.first_nr;
            b_reg      <= bus.second_nr;
            op_reg     <= bus.operation;
            neg_reg    <= bus.first_nr[W_IN-1] ^ bus.second_nr[W_IN-1];
            finish_reg <= 1'b0;
            err_reg    <= 1'b0;
            state_reg  <= (bus.operation == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_reg)
            OP_ADD: result_reg <= sext8(a_reg) + sext8(b_reg);
            OP_SUB: result_reg <= sext8(a_reg) - sext8(b_reg);
            default: begin
              result_reg <= '0;
              err_reg    <= 1'b1;
            end
          endcase
          finish_reg <= 1'b1;
          state_reg  <= ST_DONE;
        end
        ST_MUL: begin
          // The core's prod already includes the final iteration here.
          if (mul_done) begin
            result_reg <= neg_reg ? (8'd0 - mul_mag) : mul_mag;
            finish_reg <= 1'b1;
            state_reg  <= ST_DONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.result     = result_reg;
  assign bus.alu_finish = finish_reg;
  assign bus.alu_busy   = (state_reg == ST_EXEC) || (state_reg == ST_MUL);
  assign bus.op_error   = err_reg;

endmodule

// File: tb/tb_signed_alu_seq.sv
module tb_signed_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  signed_alu_seq_if bus ();

  signed_alu_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [7:0] res;
    logic       err;
  } vec_t;

  vec_t tbl [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Reference: plain signed integer arithmetic on the operand values.
  function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] op);
    int sa, sb, r;
    logic e;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    e  = 1'b0;
    case (op)
      4'd1:    r = sa + sb;
      4'd2:    r = sa - sb;
      4'd3:    r = sa * sb;
      default: begin r = 0; e = 1'b1; end
    endcase
    return {e, 8'(r)};
  endfunction

  // Full transaction from a low alu_sel: raise, capture, wait latency, check, drop.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        input logic [7:0] exp_res, input logic exp_err, input string tag);
    int lat;
    lat = (op == 4'b0011) ? 4 : 1;
    bus.first_nr  = a;
    bus.second_nr = b;
    bus.operation = op;
    bus.alu_sel   = 1'b1;
    step();
    check({tag, " busy@capture"}, 8'(bus.alu_busy), 8'd1);
    check({tag, " finish@capture"}, 8'(bus.alu_finish), 8'd0);
    check({tag, " err@capture"}, 8'(bus.op_error), 8'd0);
    for (int c = 1; c <= lat; c++) begin
      step();
      if (c < lat) begin
        check({tag, " finish early"}, 8'(bus.alu_finish), 8'd0);
        check({tag, " busy mid"}, 8'(bus.alu_busy), 8'd1);
      end
    end
    check({tag, " finish"}, 8'(bus.alu_finish), 8'd1);
    check({tag, " busy end"}, 8'(bus.alu_busy), 8'd0);
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " op_error"}, 8'(bus.op_error), 8'(exp_err));
    $display("%s a=%h b=%h op=%h result=%02h err=%0d (exp %02h/%0d)",
             tag, a, b, op, bus.result, bus.op_error, exp_res, exp_err);
    bus.alu_sel = 1'b0;
    step();
    check({tag, " hold"}, bus.result, exp_res);
  endtask

  initial begin
    logic [8:0] m;
    logic [3:0] ra, rb, rop;
    int busy_cnt;

    tbl[0]  = '{4'h3, 4'hE, 4'h1, 8'h01, 1'b0};
    tbl[1]  = '{4'h3, 4'hB, 4'h2, 8'h08, 1'b0};
    tbl[2]  = '{4'hD, 4'h5, 4'h3, 8'hF1, 1'b0};
    tbl[3]  = '{4'h8, 4'h8, 4'h3, 8'h40, 1'b0};
    tbl[4]  = '{4'h5, 4'h2, 4'hF, 8'h00, 1'b1};
    tbl[5]  = '{4'h8, 4'h8, 4'h1, 8'hF0, 1'b0};
    tbl[6]  = '{4'h8, 4'h7, 4'h2, 8'hF1, 1'b0};
    tbl[7]  = '{4'h7, 4'h8, 4'h3, 8'hC8, 1'b0};
    tbl[8]  = '{4'h1, 4'h1, 4'h0, 8'h00, 1'b1};
    tbl[9]  = '{4'h0, 4'h8, 4'h3, 8'h00, 1'b0};
    tbl[10] = '{4'h7, 4'h7, 4'h1, 8'h0E, 1'b0};
    tbl[11] = '{4'h7, 4'h8, 4'h2, 8'h0F, 1'b0};

    bus.alu_sel   = 1'b0;
    bus.first_nr  = 4'h0;
    bus.second_nr = 4'h0;
    bus.operation = 4'h0;
    rst = 1'b0;
    repeat (3) step();
    check("reset result", bus.result, 8'h00);
    check("reset finish", 8'(bus.alu_finish), 8'd0);
    check("reset busy", 8'(bus.alu_busy), 8'd0);
    check("reset err", 8'(bus.op_error), 8'd0);
    rst = 1'b1;
    step();

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].res, tbl[i].err, $sformatf("vec%0d", i));
    end

    // SUB with alu_sel held high: exactly one operation
    bus.first_nr = 4'h3; bus.second_nr = 4'hB; bus.operation = 4'h2;
    bus.alu_sel = 1'b1;
    step();
    step();
    check("hold result", bus.result, 8'h08);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.alu_busy) busy_cnt++;
    end
    check("hold no retrigger", 8'(busy_cnt), 8'd0);
    check("hold finish", 8'(bus.alu_finish), 8'd1);
    $display("hold-high SUB result=%02h busy_cycles=%0d", bus.result, busy_cnt);
    bus.alu_sel = 1'b0;
    step();

    // Reset in the middle of a MUL
    bus.first_nr = 4'hD; bus.second_nr = 4'h5; bus.operation = 4'h3;
    bus.alu_sel = 1'b1;
    step();              // edge N: capture
    step();              // edge N+1
    rst = 1'b0;
    step();              // edge N+2: reset
    check("midrst result", bus.result, 8'h00);
    check("midrst finish", 8'(bus.alu_finish), 8'd0);
    check("midrst busy", 8'(bus.alu_busy), 8'd0);
    check("midrst err", 8'(bus.op_error), 8'd0);
    $display("reset mid-MUL result=%02h busy=%0d", bus.result, bus.alu_busy);
    rst = 1'b1;
    bus.alu_sel = 1'b0;
    step();
    run_op(4'hD, 4'h5, 4'h3, 8'hF1, 1'b0, "post-reset");

    // Start pulse during MUL is ignored
    bus.first_nr = 4'h6; bus.second_nr = 4'h9; bus.operation = 4'h3;
    bus.alu_sel = 1'b1;
    step();              // N
    bus.alu_sel = 1'b0;
    step();              // N+1
    bus.first_nr = 4'h1; bus.second_nr = 4'h1; bus.operation = 4'h1;
    bus.alu_sel = 1'b1;
    step();              // N+2: ignored start
    check("ignore busy", 8'(bus.alu_busy), 8'd1);
    step();              // N+3
    step();              // N+4
    check("ignore finish", 8'(bus.alu_finish), 8'd1);
    check("ignore result", bus.result, 8'hD6);
    step();
    check("ignore no requeue", 8'(bus.alu_busy), 8'd0);
    check("ignore result held", bus.result, 8'hD6);
    $display("ignored start during MUL result=%02h", bus.result);
    bus.alu_sel = 1'b0;
    step();

    // alu_sel already high when reset releases counts as a start
    rst = 1'b0;
    bus.first_nr = 4'h2; bus.second_nr = 4'h3; bus.operation = 4'h1;
    bus.alu_sel = 1'b1;
    step();
    step();
    check("rstsel idle", 8'(bus.alu_busy), 8'd0);
    rst = 1'b1;
    step();
    check("rstsel busy", 8'(bus.alu_busy), 8'd1);
    step();
    check("rstsel finish", 8'(bus.alu_finish), 8'd1);
    check("rstsel result", bus.result, 8'h05);
    $display("start at reset release result=%02h", bus.result);
    bus.alu_sel = 1'b0;
    step();

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) rop = 4'($urandom_range(0, 15));
      else                           rop = 4'($urandom_range(1, 3));
      m = model(ra, rb, rop);
      run_op(ra, rb, rop, m[7:0], m[8], $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
